// File: rtl/store_drain_buffer_pkg.sv
// Shared types for the post-retire store drain buffer.
// The entry layout is also used by the forwarding lookup.
package store_drain_buffer_pkg;

   localparam int SB_SZ_DEF = 8;
   localparam int N_DEF     = 2;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } STOREBUF_ENTRY;

   typedef enum logic [1:0] {
      DR_IDLE  = 2'd0,
      DR_ISSUE = 2'd1,
      DR_WAIT  = 2'd2
   } drain_state_e;

endpackage

// File: rtl/store_drain_buffer_if.sv
// D-cache write port of the store drain buffer: request/ready plus a completion pulse.
interface store_drain_buffer_if;

   logic        dc_req_valid;
   logic [31:0] dc_req_addr;
   logic [31:0] dc_req_data;
   logic [3:0]  dc_req_mask;
   logic        dc_req_ready;
   logic        dc_resp_valid;

   modport master (
      output dc_req_valid, dc_req_addr, dc_req_data, dc_req_mask,
      input  dc_req_ready, dc_resp_valid
   );

   modport slave (
      input  dc_req_valid, dc_req_addr, dc_req_data, dc_req_mask,
      output dc_req_ready, dc_resp_valid
   );

endinterface

// File: rtl/store_drain_buffer_fwd.sv
// Word-granular store-to-load forwarding over the buffered stores.
// Per byte lane, the youngest matching entry wins.
module sb_fwd_lookup
   import store_drain_buffer_pkg::*;
#(
   parameter  int SB_SZ = SB_SZ_DEF,
   localparam int PW    = $clog2(SB_SZ),
   localparam int CW    = $clog2(SB_SZ + 1)
) (
   input  STOREBUF_ENTRY [SB_SZ-1:0] entries,
   input  logic [PW-1:0]             head,
   input  logic [CW-1:0]             count,
   input  logic [31:0]               ld_addr,
   output logic [3:0]                fwd_mask,
   output logic [31:0]               fwd_data
);

   logic [PW-1:0]    idx;
   logic             unused_ld_lo;
   logic [SB_SZ-1:0] unused_ent_lo;

   assign unused_ld_lo = ^ld_addr[1:0];
   for (genvar g = 0; g < SB_SZ; g++) begin : g_unused
      assign unused_ent_lo[g] = ^entries[g].addr[1:0];
   end

   // Walk from oldest to youngest so a younger covering lane overwrites an older one.
   always_comb begin
      fwd_mask = 4'b0000;
      fwd_data = 32'h0000_0000;
      idx      = head;
      for (int k = 0; k < SB_SZ; k++) begin
         idx = head + PW'(k);
         if ((k < int'(count)) && entries[idx].valid &&
             (entries[idx].addr[31:2] == ld_addr[31:2])) begin
            for (int b = 0; b < 4; b++) begin
               if (entries[idx].mask[b]) begin
                  fwd_mask[b]        = 1'b1;
                  fwd_data[8*b +: 8] = entries[idx].data[8*b +: 8];
               end else begin
                  fwd_mask[b] = fwd_mask[b];
               end
            end
         end else begin
            fwd_mask = fwd_mask;
         end
      end
   end

endmodule

// File: rtl/store_drain_buffer.sv
// Post-retire store buffer: circular FIFO of committed stores drained one at a time
// to the D-cache, with byte-merged forwarding to the load path.
module store_drain_buffer
   import store_drain_buffer_pkg::*;
#(
   parameter  int SB_SZ = SB_SZ_DEF,
   parameter  int N     = N_DEF,
   localparam int PW    = $clog2(SB_SZ),
   localparam int CW    = $clog2(SB_SZ + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N-1:0]         ret_valid,
   input  logic [N-1:0][31:0]   ret_addr,
   input  logic [N-1:0][31:0]   ret_data,
   input  logic [N-1:0][3:0]    ret_mask,
   output logic [CW-1:0]        free_slots,
   output logic                 empty,
   store_drain_buffer_if.master dc,
   input  logic [31:0]          ld_addr,
   output logic [3:0]           ld_fwd_mask,
   output logic [31:0]          ld_fwd_data
);

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   STOREBUF_ENTRY [SB_SZ-1:0] entries;
   drain_state_e              state;
   logic [PW-1:0]             head, head_inc, tail;
   logic [CW-1:0]             count, count_nxt, enq_cnt, pop_ext;
   logic [N-1:0][PW-1:0]      enq_idx;
   logic                      pop, req_valid;
   logic [31:0]               req_addr, req_data;
   logic [3:0]                req_mask;

   assign pop       = (state == DR_WAIT) && dc.dc_resp_valid;
   assign pop_ext   = {{(CW-1){1'b0}}, pop};
   assign head_inc  = head + {{(PW-1){1'b0}}, 1'b1};
   assign count_nxt = count + enq_cnt - pop_ext;

   // The i-th valid retire lane lands i slots past tail.
   always_comb begin
      enq_cnt = CNT_ZERO;
      enq_idx = {(N*PW){1'b0}};
      for (int i = 0; i < N; i++) begin
         enq_idx[i] = tail + enq_cnt[PW-1:0];
         if (ret_valid[i]) begin
            enq_cnt = enq_cnt + CNT_ONE;
         end else begin
            enq_cnt = enq_cnt;
         end
      end
   end

   // Entry storage, tail pointer and occupancy counters.
   always_ff @(posedge clock) begin
      if (!reset) begin
         entries    <= '0;
         tail       <= {PW{1'b0}};
         count      <= CNT_ZERO;
         free_slots <= CW'(SB_SZ);
      end else begin
         if (pop) entries[head].valid <= 1'b0;
         for (int i = 0; i < N; i++) begin
            if (ret_valid[i]) begin
               entries[enq_idx[i]] <= '{valid: 1'b1, addr: ret_addr[i],
                                        data: ret_data[i], mask: ret_mask[i]};
            end
         end
         tail       <= tail + enq_cnt[PW-1:0];
         count      <= count_nxt;
         free_slots <= free_slots + pop_ext - enq_cnt;
      end
   end

   // Drain sequencer; the in-flight entry stays valid until its response pops it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= DR_IDLE;
         head      <= {PW{1'b0}};
         req_valid <= 1'b0;
         req_addr  <= 32'h0000_0000;
         req_data  <= 32'h0000_0000;
         req_mask  <= 4'b0000;
         empty     <= 1'b1;
      end else begin
         case (state)
            DR_IDLE: begin
               if (count != CNT_ZERO) begin
                  state     <= DR_ISSUE;
                  req_valid <= 1'b1;
                  req_addr  <= entries[head].addr;
                  req_data  <= entries[head].data;
                  req_mask  <= entries[head].mask;
                  empty     <= 1'b0;
               end else begin
                  empty     <= (count_nxt == CNT_ZERO);
               end
            end
            DR_ISSUE: begin
               empty <= 1'b0;
               if (dc.dc_req_ready) begin
                  state     <= DR_WAIT;
                  req_valid <= 1'b0;
               end
            end
            DR_WAIT: begin
               if (dc.dc_resp_valid) begin
                  head <= head_inc;
                  // Stores enqueued this very cycle are picked up next cycle via IDLE.
                  if (count > CNT_ONE) begin
                     state     <= DR_ISSUE;
                     req_valid <= 1'b1;
                     req_addr  <= entries[head_inc].addr;
                     req_data  <= entries[head_inc].data;
                     req_mask  <= entries[head_inc].mask;
                     empty     <= 1'b0;
                  end else begin
                     state     <= DR_IDLE;
                     empty     <= (count_nxt == CNT_ZERO);
                  end
               end else begin
                  empty <= 1'b0;
               end
            end
            default: begin
               state     <= DR_IDLE;
               req_valid <= 1'b0;
               empty     <= (count_nxt == CNT_ZERO);
            end
         endcase
      end
   end

   assign dc.dc_req_valid = req_valid;
   assign dc.dc_req_addr  = req_addr;
   assign dc.dc_req_data  = req_data;
   assign dc.dc_req_mask  = req_mask;

   sb_fwd_lookup #(.SB_SZ(SB_SZ)) u_fwd (
      .entries  (entries),
      .head     (head),
      .count    (count),
      .ld_addr  (ld_addr),
      .fwd_mask (ld_fwd_mask),
      .fwd_data (ld_fwd_data)
   );

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_store_drain_buffer;

   localparam int SB = 8;
   localparam int NR = 2;

   logic                clock, reset;
   logic [NR-1:0]       ret_valid;
   logic [NR-1:0][31:0] ret_addr, ret_data;
   logic [NR-1:0][3:0]  ret_mask;
   logic [3:0]          free_slots;
   logic                empty;
   logic [31:0]         ld_addr;
   logic [3:0]          ld_fwd_mask;
   logic [31:0]         ld_fwd_data;

   store_drain_buffer_if ifc ();

   store_drain_buffer #(.SB_SZ(SB), .N(NR)) dut (
      .clock       (clock),
      .reset       (reset),
      .ret_valid   (ret_valid),
      .ret_addr    (ret_addr),
      .ret_data    (ret_data),
      .ret_mask    (ret_mask),
      .free_slots  (free_slots),
      .empty       (empty),
      .dc          (ifc.master),
      .ld_addr     (ld_addr),
      .ld_fwd_mask (ld_fwd_mask),
      .ld_fwd_data (ld_fwd_data)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } st_t;

   st_t         mq[$];
   st_t         m_e;
   bit          m_req, m_wait;
   int          m_n;
   int          total, bad;
   bit          chk_en;
   int          pend, resp_delay;
   bit          auto_resp;
   logic [31:0] retired_addr[$];
   logic [31:0] fired_addr[$];
   logic [3:0]  em;
   logic [31:0] ed;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_fwd(input logic [31:0] a, output logic [3:0] m, output logic [31:0] d);
      m = 4'h0;
      d = 32'h0;
      foreach (mq[j]) begin
         if (mq[j].addr[31:2] == a[31:2]) begin
            for (int b = 0; b < 4; b++) begin
               if (mq[j].mask[b]) begin
                  m[b]        = 1'b1;
                  d[8*b +: 8] = mq[j].data[8*b +: 8];
               end
            end
         end
      end
   endfunction

   // Reference model: FIFO of committed stores plus the request/response phase.
   initial begin
      forever begin
         @(posedge clock);
         if (!reset) begin
            mq.delete();
            m_req  = 1'b0;
            m_wait = 1'b0;
         end else begin
            m_n = mq.size();
            if (ret_valid != 2'b00)
               chk("retire_room", {31'b0, ($countones(ret_valid) <= (SB - m_n))}, 32'd1);
            if (m_wait) begin
               if (ifc.dc_resp_valid) begin
                  void'(mq.pop_front());
                  m_wait = 1'b0;
                  m_req  = (m_n - 1) > 0;
               end
            end else if (m_req) begin
               if (ifc.dc_req_ready) begin
                  m_req  = 1'b0;
                  m_wait = 1'b1;
               end
            end else if (m_n > 0) begin
               m_req = 1'b1;
            end
            for (int i = 0; i < NR; i++) begin
               if (ret_valid[i]) begin
                  m_e.addr = ret_addr[i];
                  m_e.data = ret_data[i];
                  m_e.mask = ret_mask[i];
                  mq.push_back(m_e);
               end
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clock);
         if (chk_en) begin
            chk("free_slots", 32'(free_slots), 32'(SB - mq.size()));
            chk("empty", {31'b0, empty}, {31'b0, (mq.size() == 0) && !m_req && !m_wait});
            chk("req_valid", {31'b0, ifc.dc_req_valid}, {31'b0, m_req});
            if (m_req && mq.size() > 0) begin
               chk("req_addr", ifc.dc_req_addr, mq[0].addr);
               chk("req_data", ifc.dc_req_data, mq[0].data);
               chk("req_mask", 32'(ifc.dc_req_mask), 32'(mq[0].mask));
            end
            model_fwd(ld_addr, em, ed);
            chk("fwd_mask", 32'(ld_fwd_mask), 32'(em));
            chk("fwd_data", ld_fwd_data, ed);
         end
      end
   end

   // One clock; also plays the D-cache response side when auto_resp is set.
   task automatic step();
      bit fire, rst_edge;
      fire = ifc.dc_req_valid && ifc.dc_req_ready;
      if (fire) fired_addr.push_back(ifc.dc_req_addr);
      @(posedge clock);
      rst_edge = !reset;
      #1;
      ret_valid         = 2'b00;
      ifc.dc_resp_valid = 1'b0;
      if (rst_edge) pend = 0;
      else if (fire && auto_resp) pend = resp_delay;
      if (pend > 0) begin
         pend--;
         if (pend == 0) ifc.dc_resp_valid = 1'b1;
      end
   endtask

   task automatic put(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      ret_valid[i] = 1'b1;
      ret_addr[i]  = a;
      ret_data[i]  = d;
      ret_mask[i]  = m;
      retired_addr.push_back(a);
   endtask

   task automatic wait_empty(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (empty) break;
         step();
      end
      chk(name, {31'b0, empty}, 32'd1);
   endtask

   initial begin
      reset             = 1'b0;
      ret_valid         = 2'b00;
      ret_addr          = '0;
      ret_data          = '0;
      ret_mask          = '0;
      ld_addr           = 32'h0;
      ifc.dc_req_ready  = 1'b0;
      ifc.dc_resp_valid = 1'b0;
      auto_resp         = 1'b1;
      resp_delay        = 1;
      pend              = 0;
      chk_en            = 1'b0;
      total             = 0;
      bad               = 0;

      // Reset and idle
      step(); step();
      reset  = 1'b1;
      chk_en = 1'b1;
      chk("rst_free", 32'(free_slots), 32'd8);
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_req_valid", {31'b0, ifc.dc_req_valid}, 32'd0);
      chk("rst_fwd_mask", 32'(ld_fwd_mask), 32'd0);
      chk("rst_fwd_data", ld_fwd_data, 32'd0);

      // Single drain, response three cycles after the request fires
      ifc.dc_req_ready = 1'b1;
      resp_delay       = 3;
      ld_addr          = 32'h0000_1001;
      put(0, 32'h0000_1000, 32'hAABB_CCDD, 4'hF);
      step();
      chk("sd_free_7", 32'(free_slots), 32'd7);
      chk("sd_no_req_yet", {31'b0, ifc.dc_req_valid}, 32'd0);
      step();
      chk("sd_req_valid", {31'b0, ifc.dc_req_valid}, 32'd1);
      chk("sd_req_addr", ifc.dc_req_addr, 32'h0000_1000);
      chk("sd_req_data", ifc.dc_req_data, 32'hAABB_CCDD);
      chk("sd_req_mask", 32'(ifc.dc_req_mask), 32'hF);
      step();
      chk("sd_wait_valid", {31'b0, ifc.dc_req_valid}, 32'd0);
      chk("sd_inflight_free", 32'(free_slots), 32'd7);
      chk("sd_inflight_fwd_mask", 32'(ld_fwd_mask), 32'hF);
      chk("sd_inflight_fwd_data", ld_fwd_data, 32'hAABB_CCDD);
      wait_empty(20, "sd_drained");
      chk("sd_free_8", 32'(free_slots), 32'd8);

      // Fill to full with the cache stalled, then drain across the pointer wrap
      retired_addr.delete();
      fired_addr.delete();
      ifc.dc_req_ready = 1'b0;
      ld_addr          = 32'h0000_5010;
      for (int c = 0; c < 4; c++) begin
         put(0, 32'h0000_5000 + 32'(c * 32), 32'hD000_0000 + 32'(c * 2), 4'hF);
         put(1, 32'h0000_5010 + 32'(c * 32), 32'hD000_0001 + 32'(c * 2), 4'h3);
         step();
      end
      chk("fill_free_0", 32'(free_slots), 32'd0);
      chk("fill_head_addr", ifc.dc_req_addr, 32'h0000_5000);
      ifc.dc_req_ready = 1'b1;
      resp_delay       = 1;
      wait_empty(60, "fill_drained");
      for (int c = 0; c < 4; c++) begin
         put(0, 32'h0000_6000 + 32'(c * 32), 32'hE000_0000 + 32'(c), 4'hC);
         put(1, 32'h0000_6010 + 32'(c * 32), 32'hE100_0000 + 32'(c), 4'h1);
         step();
      end
      wait_empty(60, "wrap_drained");
      chk("order_count", 32'(fired_addr.size()), 32'd16);
      for (int j = 0; j < 16 && j < fired_addr.size(); j++)
         chk("drain_order", fired_addr[j], retired_addr[j]);

      // Forward merge, then a same-word pair straddling the wrap
      ifc.dc_req_ready = 1'b0;
      put(0, 32'h0000_2000, 32'h1111_1111, 4'h3);
      step();
      put(0, 32'h0000_2000, 32'h2222_2222, 4'h6);
      step();
      ld_addr = 32'h0000_2002;
      #1;
      chk("merge_mask", 32'(ld_fwd_mask), 32'h7);
      chk("merge_data", ld_fwd_data, 32'h0022_2211);
      ld_addr = 32'h0000_2004;
      #1;
      chk("miss_mask", 32'(ld_fwd_mask), 32'h0);
      put(0, 32'h0000_3000, 32'h3000_0000, 4'hF);
      put(1, 32'h0000_3010, 32'h3000_0001, 4'hF);
      step();
      put(0, 32'h0000_3020, 32'h3000_0002, 4'hF);
      put(1, 32'h0000_3030, 32'h3000_0003, 4'hF);
      step();
      put(0, 32'h0000_4000, 32'hAAAA_AAAA, 4'hF);
      put(1, 32'h0000_4000, 32'hBBBB_BBBB, 4'h3);
      step();
      ld_addr = 32'h0000_4000;
      #1;
      chk("wrap_fwd_mask", 32'(ld_fwd_mask), 32'hF);
      chk("wrap_fwd_data", ld_fwd_data, 32'hAAAA_BBBB);
      chk("full_free_0", 32'(free_slots), 32'd0);

      // Response and two retires in the same cycle with three free slots
      auto_resp = 1'b0;
      for (int p = 0; p < 3; p++) begin
         ifc.dc_req_ready = 1'b1;
         step();
         ifc.dc_req_ready  = 1'b0;
         ifc.dc_resp_valid = 1'b1;
         step();
      end
      chk("sim_free_3", 32'(free_slots), 32'd3);
      ifc.dc_req_ready = 1'b1;
      step();
      ifc.dc_req_ready = 1'b0;
      chk("sim_wait_valid", {31'b0, ifc.dc_req_valid}, 32'd0);
      put(0, 32'h0000_7000, 32'h7777_0000, 4'hF);
      put(1, 32'h0000_7010, 32'h7777_0001, 4'hF);
      ifc.dc_resp_valid = 1'b1;
      step();
      chk("sim_free_2", 32'(free_slots), 32'd2);
      chk("sim_reissue", {31'b0, ifc.dc_req_valid}, 32'd1);
      chk("sim_new_head", ifc.dc_req_addr, 32'h0000_3020);
      auto_resp        = 1'b1;
      resp_delay       = 2;
      ifc.dc_req_ready = 1'b1;
      wait_empty(60, "sim_drained");

      // Reset while waiting for a response; a late response must be ignored
      auto_resp        = 1'b0;
      ld_addr          = 32'h0000_8000;
      put(0, 32'h0000_8000, 32'h1234_5678, 4'hF);
      step();
      step();
      step();
      ifc.dc_req_ready = 1'b0;
      chk("rm_in_wait_valid", {31'b0, ifc.dc_req_valid}, 32'd0);
      chk("rm_in_wait_free", 32'(free_slots), 32'd7);
      reset = 1'b0;
      step();
      reset             = 1'b1;
      ifc.dc_resp_valid = 1'b1;
      step();
      chk("rm_free_8", 32'(free_slots), 32'd8);
      chk("rm_empty", {31'b0, empty}, 32'd1);
      chk("rm_req_valid", {31'b0, ifc.dc_req_valid}, 32'd0);
      chk("rm_fwd_mask", 32'(ld_fwd_mask), 32'd0);
      step();
      step();
      chk("rm_still_idle", {31'b0, ifc.dc_req_valid}, 32'd0);
      chk("rm_still_empty", {31'b0, empty}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/store_drain_buffer.md
# store_drain_buffer

Post-retire store buffer between the store queue and the data cache. It accepts up to `N` retired stores per cycle from the store queue head and holds them in a circular FIFO. It drains them one at a time, oldest first, to the D-cache over a request/ready plus response handshake. It also gives the load path word-granular, byte-merged forwarding of pending store data. Mispredict recovery never touches it, because every entry is architecturally committed.

## Interface
Parameters:
- `SB_SZ`, 8: buffer depth; power of two, at least 2.
- `N`, `` `N ``: retire width (stores accepted per cycle).

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low: when `reset`==0 at a rising edge, all state is cleared.
- `ret_valid`  in  N  retired stores this cycle; contiguous from bit 0.
- `ret_addr`  in  N×32  byte address per retired store.
- `ret_data`  in  N×32  store data, already lane-aligned.
- `ret_mask`  in  N×4  byte enables; never zero when valid.
- `free_slots`  out  $clog2(SB_SZ+1)  registered count of free entries; retire uses it to throttle.
- `empty`  out  1  high when the buffer holds no entries and nothing is in flight.
- `dc_req_valid`  out  1  head store presented to the D-cache.
- `dc_req_addr` / `dc_req_data` / `dc_req_mask`  out  32 / 32 / 4  head entry fields.
- `dc_req_ready`  in  1  D-cache accepts the request this cycle.
- `dc_resp_valid`  in  1  D-cache reports the write of the in-flight store complete.
- `ld_addr`  in  32  load lookup address; bits [1:0] are ignored.
- `ld_fwd_mask`  out  4  bytes of the word supplied by the buffer; combinational.
- `ld_fwd_data`  out  32  merged forwarded bytes; lanes outside `ld_fwd_mask` are 0.

## Operation
- Storage: `SB_SZ` entries, each {valid, addr, data, mask}. Pointers `head` and `tail` are $clog2(SB_SZ) bits and wrap modulo `SB_SZ`. There is a registered `count`.
- Enqueue: the i-th set bit of `ret_valid` writes entry `(tail+i)%SB_SZ`, and `tail` advances by popcount(`ret_valid`). The caller guarantees popcount ≤ `free_slots`; the bench asserts this, and behaviour on violation is undefined.
- Drain FSM:
  - IDLE: `dc_req_valid`=0. Go to ISSUE when `count`>0.
  - ISSUE: `dc_req_valid`=1 with the fields of entry `head`. On `dc_req_ready`, go to WAIT.
  - WAIT: `dc_req_valid`=0. On `dc_resp_valid`, clear entry `head`, advance `head` by 1 and decrement `count`. Then go to ISSUE if remaining `count`>0, otherwise IDLE.
  - `dc_resp_valid` outside WAIT is ignored.
- The in-flight entry stays valid and stays forwardable until its response arrives.
- Forwarding: compare `ld_addr[31:2]` against every valid entry. For each byte lane, take the data from the youngest matching entry whose mask covers that lane; age is measured from `head` to `tail`. `ld_fwd_mask` is the OR of covered lanes. The load unit decides whether a partial hit means stall or merge.
- Free count: `free_slots_next` = `free_slots` + popped − enqueued, where popped ∈ {0,1}.
- `empty` = (`count`==0) && (state==IDLE).

## Timing
- Reset (`reset`==0 at an edge) gives: all entries invalid, `head`=`tail`=0, `count`=0, state IDLE, `free_slots`=SB_SZ, `empty`=1, `dc_req_valid`=0, `ld_fwd_mask`=0, `ld_fwd_data`=0.
- Reset mid-drain discards the outstanding request. A `dc_resp_valid` arriving after reset is ignored because the FSM is in IDLE.
- A store enqueued at edge t is forwardable and drainable from cycle t+1. At the earliest, `dc_req_valid` rises in cycle t+2: IDLE→ISSUE takes one edge.
- Request handshake: the request fires in a cycle where `dc_req_valid`&&`dc_req_ready`. The earliest legal response is the following cycle. Steady-state throughput is therefore one store per 2 cycles.
- Enqueue and pop in the same cycle are both applied, so `free_slots` changes by 1 − k.
- Full buffer (`free_slots`=0): the retire port must present no valid stores. Draining continues normally.
- Wrap-around: pointers roll from SB_SZ−1 to 0. Forwarding age order stays correct across the wrap.
- `free_slots`, `empty` and all `dc_req_*` outputs are functions of registers only. `ld_fwd_*` are combinational from `ld_addr` and registers.

## Structure
- Put `STOREBUF_ENTRY` ({valid, addr, data, mask}) and the `SB_SZ` default in the shared `sys_defs.svh`, next to the store queue types.
- Make the forwarding logic a sub-module, `sb_fwd_lookup`. It takes the entries, `head`, `count` and `ld_addr`, and produces the mask and data. It is purely combinational with a per-lane youngest-match priority.
- The FSM, pointers and counters stay in the top module.

## Test plan
- Reset and idle: hold `reset`=0 for 2 cycles, then release → `free_slots`=8, `empty`=1, `dc_req_valid`=0, `ld_fwd_mask`=0.
- Single drain: retire one store {0x1000, 0xAABBCCDD, 0xF}. Hold `dc_req_ready`=1 and respond 3 cycles later → the request is seen with those fields; the entry pops on the response; `free_slots` goes 8→7→8; `empty` returns to 1.
- Fill and wrap: retire 2 stores per cycle until `free_slots`=0, with the cache stalled. Then drain all 8 and retire 8 more → drain order matches retire order exactly across the pointer wrap.
- Forward merge: retire {0x2000, 0x11111111, 0x3}, then {0x2000, 0x22222222, 0x6}. Look up `ld_addr`=0x2002 → `ld_fwd_mask`=0x7, `ld_fwd_data`=0x00222211.
- Simultaneous events: in the same cycle, retire 2 stores while the in-flight response arrives with `free_slots`=3 → next-cycle `free_slots`=2, and the FSM re-enters ISSUE with the new head.
- Reset mid-operation: reset while in WAIT, with `dc_resp_valid` asserted the cycle after release → the response is ignored, `count`=0, and `dc_req_valid` stays 0.
